// File: rtl/adc_mux_sequencer_if.sv
// Sequencer bus: control inputs, SAR ADC handshake and the tagged result stream to the router.
interface adc_mux_sequencer_if #(
  parameter int unsigned ADC_BITS = 10
);
  logic                enable;
  logic                err_clr;
  logic                adc_done;
  logic [ADC_BITS-1:0] adc_data;
  logic [1:0]          amux_sel;
  logic                adc_start;
  logic [ADC_BITS-1:0] adc_code;
  logic                adc_valid;
  logic [1:0]          mux_sel;
  logic                frame_done;
  logic                timeout_err;
  logic                busy;

  modport master (
    input  enable, err_clr, adc_done, adc_data,
    output amux_sel, adc_start, adc_code, adc_valid, mux_sel, frame_done, timeout_err, busy
  );

  modport slave (
    output enable, err_clr, adc_done, adc_data,
    input  amux_sel, adc_start, adc_code, adc_valid, mux_sel, frame_done, timeout_err, busy
  );
endinterface

// File: rtl/adc_mux_sequencer.sv
// Steps the analog mux X->Y->Z, settles, runs one SAR conversion per slot and
// hands each result to the router with a channel tag; flags stuck conversions.
module adc_mux_sequencer #(
  parameter int unsigned ADC_BITS      = 10,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned CONV_TIMEOUT  = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  adc_mux_sequencer_if.master bus
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned CH_W  = 2;
  localparam logic [CNT_W-1:0] SETTLE_LOAD  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(CONV_TIMEOUT - 1);
  localparam logic [CH_W-1:0]  CH_X = CH_W'(0);
  localparam logic [CH_W-1:0]  CH_Y = CH_W'(1);
  localparam logic [CH_W-1:0]  CH_Z = CH_W'(2);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_START  = 2'd2,
    S_CONV   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    settle_q, settle_d;
  logic [CNT_W-1:0]    tout_q, tout_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [CH_W-1:0]     amux_q, amux_d;
  logic [CH_W-1:0]     tag_q, tag_d;
  logic [ADC_BITS-1:0] code_q, code_d;
  logic                start_q, start_d;
  logic                valid_q, valid_d;
  logic                frame_q, frame_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;
  logic                slot_end;
  logic [CH_W-1:0]     next_ch;

  // State and output registers; reset abandons any conversion in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      settle_q <= '0;
      tout_q   <= '0;
      ch_q     <= CH_X;
      amux_q   <= CH_X;
      tag_q    <= CH_X;
      code_q   <= '0;
      start_q  <= 1'b0;
      valid_q  <= 1'b0;
      frame_q  <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      tout_q   <= tout_d;
      ch_q     <= ch_d;
      amux_q   <= amux_d;
      tag_q    <= tag_d;
      code_q   <= code_d;
      start_q  <= start_d;
      valid_q  <= valid_d;
      frame_q  <= frame_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
    end
  end

  assign next_ch = (ch_q == CH_Z) ? CH_X : ((ch_q == CH_X) ? CH_Y : CH_Z);

  // Next-state and next-output logic; pulses default low, data holds.
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    tout_d   = tout_q;
    ch_d     = ch_q;
    amux_d   = amux_q;
    tag_d    = tag_q;
    code_d   = code_q;
    start_d  = 1'b0;
    valid_d  = 1'b0;
    frame_d  = 1'b0;
    err_d    = bus.err_clr ? 1'b0 : err_q;
    slot_end = 1'b0;

    case (state_q)
      S_IDLE: begin
        ch_d   = CH_X;
        amux_d = CH_X;
        if (bus.enable) begin
          state_d  = S_SETTLE;
          settle_d = SETTLE_LOAD;
        end
      end

      S_SETTLE: begin
        if (!bus.enable) begin
          state_d = S_IDLE;
          ch_d    = CH_X;
          amux_d  = CH_X;
        end else if (settle_q == '0) begin
          state_d = S_START;
          start_d = 1'b1;
        end else begin
          settle_d = settle_q - CNT_W'(1);
        end
      end

      S_START: begin
        state_d = S_CONV;
        tout_d  = '0;
      end

      S_CONV: begin
        // A completing conversion beats a coincident timeout.
        if (bus.adc_done) begin
          code_d   = bus.adc_data;
          tag_d    = ch_q;
          valid_d  = 1'b1;
          slot_end = 1'b1;
        end else if (tout_q == TIMEOUT_LAST) begin
          err_d    = 1'b1;
          slot_end = 1'b1;
        end else begin
          tout_d = tout_q + CNT_W'(1);
        end

        if (slot_end) begin
          frame_d = (ch_q == CH_Z);
          if (bus.enable) begin
            state_d  = S_SETTLE;
            settle_d = SETTLE_LOAD;
            ch_d     = next_ch;
            amux_d   = next_ch;
          end else begin
            state_d = S_IDLE;
            ch_d    = CH_X;
            amux_d  = CH_X;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        ch_d    = CH_X;
        amux_d  = CH_X;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign bus.amux_sel    = amux_q;
  assign bus.adc_start   = start_q;
  assign bus.adc_code    = code_q;
  assign bus.adc_valid   = valid_q;
  assign bus.mux_sel     = tag_q;
  assign bus.frame_done  = frame_q;
  assign bus.timeout_err = err_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_adc_mux_sequencer.sv
// Directed bench for adc_mux_sequencer with a behavioural SAR ADC model and a result monitor.
module tb_adc_mux_sequencer;

  logic clk;
  logic rst_n;
  adc_mux_sequencer_if #(.ADC_BITS(10)) bus ();

  adc_mux_sequencer #(
    .ADC_BITS(10),
    .SETTLE_CYCLES(4),
    .CONV_TIMEOUT(64)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // ADC model configuration: per-channel latency (0 = never answers) and code.
  int          lat_ch[4];
  logic [9:0]  code_ch[4];
  bit          rand_mode = 0;
  bit          inject = 0;
  int          pend = 0;
  int          mdl_lat = 0;
  logic [9:0]  pend_code = '0;
  int          lat_q[$];

  // Monitor records.
  int vq_tag[$];
  int vq_code[$];
  int vq_cyc[$];
  int vq_amux[$];
  int frame_cnt = 0;
  int frame_cyc = 0;
  int err_cyc = 0;
  int err_code = 0;
  int err_tag = 0;
  int consec_viol = 0;
  int bad_tag = 0;
  bit prev_valid = 0;
  bit prev_err = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ADC: answers adc_start after the configured number of cycles.
  initial begin
    bus.adc_done = 1'b0;
    bus.adc_data = '0;
    forever begin
      @(negedge clk);
      bus.adc_done = 1'b0;
      if (!rst_n) begin
        pend = 0;
      end else begin
        if (inject) begin
          bus.adc_done = 1'b1;
          bus.adc_data = 10'h155;
          inject = 0;
        end
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            bus.adc_done = 1'b1;
            bus.adc_data = pend_code;
          end
        end
        if (bus.adc_start) begin
          mdl_lat = rand_mode ? int'($urandom_range(20, 3)) : lat_ch[bus.amux_sel];
          if (rand_mode) lat_q.push_back(mdl_lat);
          pend = mdl_lat;
          pend_code = code_ch[bus.amux_sel];
        end
      end
    end
  end

  // Result monitor.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      prev_valid = 0;
      prev_err = 0;
    end else begin
      if (bus.adc_valid) begin
        vq_tag.push_back(int'(bus.mux_sel));
        vq_code.push_back(int'(bus.adc_code));
        vq_cyc.push_back(cyc);
        vq_amux.push_back(int'(bus.amux_sel));
        if (prev_valid) consec_viol++;
        if (bus.mux_sel == 2'd3) bad_tag++;
      end
      if (bus.frame_done) begin
        frame_cnt++;
        frame_cyc = cyc;
      end
      if (bus.timeout_err && !prev_err) begin
        err_cyc = cyc;
        err_code = int'(bus.adc_code);
        err_tag = int'(bus.mux_sel);
      end
      prev_valid = bus.adc_valid;
      prev_err = bus.timeout_err;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_vcount(input int n, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      tick(1);
      if (vq_tag.size() >= n) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.enable = 1'b0;
    bus.err_clr = 1'b0;
    tick(3);
    checks++; if (bus.amux_sel !== 2'd0) begin errors++; $display("FAIL reset_amux_sel: got %0d expected 0", bus.amux_sel); end
    checks++; if (bus.adc_start !== 1'b0) begin errors++; $display("FAIL reset_adc_start: got %0b expected 0", bus.adc_start); end
    checks++; if (bus.adc_code !== 10'h000) begin errors++; $display("FAIL reset_adc_code: got %0h expected 0", bus.adc_code); end
    checks++; if (bus.adc_valid !== 1'b0) begin errors++; $display("FAIL reset_adc_valid: got %0b expected 0", bus.adc_valid); end
    checks++; if (bus.mux_sel !== 2'd0) begin errors++; $display("FAIL reset_mux_sel: got %0d expected 0", bus.mux_sel); end
    checks++; if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %0b expected 0", bus.frame_done); end
    checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err: got %0b expected 0", bus.timeout_err); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", bus.busy); end
    rst_n = 1'b1;
    tick(2);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %0b expected 0", bus.busy); end
  endtask

  task automatic test_basic_frame();
    int b, fb, t0;
    bit ok;
    b = vq_tag.size();
    fb = frame_cnt;
    lat_ch = '{10, 10, 10, 0};
    code_ch = '{10'h000, 10'h200, 10'h3FF, 10'h000};
    t0 = cyc;
    bus.enable = 1'b1;
    wait_vcount(b + 3, 200, ok);
    bus.enable = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL basic_wait: got %0d results expected 3", vq_tag.size() - b); end
    if (ok) begin
      for (int j = 0; j < 3; j++) begin
        checks++; if (vq_tag[b+j] != j) begin errors++; $display("FAIL basic_tag%0d: got %0d expected %0d", j, vq_tag[b+j], j); end
        checks++; if (vq_code[b+j] != int'(code_ch[j])) begin errors++; $display("FAIL basic_code%0d: got %0h expected %0h", j, vq_code[b+j], code_ch[j]); end
        checks++; if (vq_amux[b+j] != (j + 1) % 3) begin errors++; $display("FAIL basic_amux%0d: got %0d expected %0d", j, vq_amux[b+j], (j + 1) % 3); end
      end
      checks++; if (vq_cyc[b] - t0 != 16) begin errors++; $display("FAIL basic_latency: got %0d expected 16", vq_cyc[b] - t0); end
      for (int j = 1; j < 3; j++) begin
        checks++; if (vq_cyc[b+j] - vq_cyc[b+j-1] != 15) begin errors++; $display("FAIL basic_spacing%0d: got %0d expected 15", j, vq_cyc[b+j] - vq_cyc[b+j-1]); end
      end
      checks++; if (frame_cnt - fb != 1) begin errors++; $display("FAIL basic_frame_cnt: got %0d expected 1", frame_cnt - fb); end
      checks++; if (frame_cyc != vq_cyc[b+2]) begin errors++; $display("FAIL basic_frame_cyc: got %0d expected %0d", frame_cyc, vq_cyc[b+2]); end
    end
    tick(3);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL basic_idle_busy: got %0b expected 0", bus.busy); end
  endtask

  task automatic test_timeout();
    int b, fb;
    bit ok;
    b = vq_tag.size();
    fb = frame_cnt;
    lat_ch = '{10, 0, 10, 0};
    code_ch = '{10'h0AA, 10'h2BB, 10'h3CC, 10'h000};
    bus.enable = 1'b1;
    wait_vcount(b + 2, 300, ok);
    bus.enable = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL timeout_wait: got %0d results expected 2", vq_tag.size() - b); end
    if (ok) begin
      checks++; if (vq_tag[b] != 0) begin errors++; $display("FAIL timeout_x_tag: got %0d expected 0", vq_tag[b]); end
      checks++; if (vq_tag[b+1] != 2) begin errors++; $display("FAIL timeout_z_tag: got %0d expected 2", vq_tag[b+1]); end
      checks++; if (vq_code[b+1] != 'h3CC) begin errors++; $display("FAIL timeout_z_code: got %0h expected 3cc", vq_code[b+1]); end
      checks++; if (err_cyc - vq_cyc[b] != 69) begin errors++; $display("FAIL timeout_err_time: got %0d expected 69", err_cyc - vq_cyc[b]); end
      checks++; if (err_code != 'h0AA || err_tag != 0) begin errors++; $display("FAIL timeout_hold: got code %0h tag %0d expected code aa tag 0", err_code, err_tag); end
      checks++; if (vq_cyc[b+1] - vq_cyc[b] != 84) begin errors++; $display("FAIL timeout_z_spacing: got %0d expected 84", vq_cyc[b+1] - vq_cyc[b]); end
      checks++; if (frame_cnt - fb != 1 || frame_cyc != vq_cyc[b+1]) begin errors++; $display("FAIL timeout_frame: got cnt %0d cyc %0d expected cnt 1 cyc %0d", frame_cnt - fb, frame_cyc, vq_cyc[b+1]); end
    end
    tick(2);
    checks++; if (bus.timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_err_sticky: got %0b expected 1", bus.timeout_err); end
    bus.err_clr = 1'b1;
    tick(1);
    bus.err_clr = 1'b0;
    checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL timeout_err_clr: got %0b expected 0", bus.timeout_err); end
  endtask

  task automatic test_late_done();
    int b, t0;
    bit ok;
    b = vq_tag.size();
    lat_ch = '{64, 10, 10, 0};
    code_ch = '{10'h1E5, 10'h000, 10'h000, 10'h000};
    t0 = cyc;
    bus.enable = 1'b1;
    wait_vcount(b + 1, 200, ok);
    bus.enable = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL late_wait: got %0d results expected 1", vq_tag.size() - b); end
    if (ok) begin
      checks++; if (vq_code[b] != 'h1E5 || vq_tag[b] != 0) begin errors++; $display("FAIL late_result: got code %0h tag %0d expected code 1e5 tag 0", vq_code[b], vq_tag[b]); end
      checks++; if (vq_cyc[b] - t0 != 70) begin errors++; $display("FAIL late_latency: got %0d expected 70", vq_cyc[b] - t0); end
    end
    checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL late_no_err: got %0b expected 0", bus.timeout_err); end
    // Stray done pulses while idle and while settling.
    tick(5);
    inject = 1;
    tick(5);
    checks++; if (vq_tag.size() != b + 1) begin errors++; $display("FAIL idle_done_ignored: got %0d results expected %0d", vq_tag.size(), b + 1); end
    lat_ch = '{10, 10, 10, 0};
    code_ch = '{10'h0F0, 10'h000, 10'h000, 10'h000};
    t0 = cyc;
    bus.enable = 1'b1;
    tick(1);
    inject = 1;
    wait_vcount(b + 2, 100, ok);
    bus.enable = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL settle_wait: got %0d results expected 2", vq_tag.size() - b); end
    if (ok) begin
      checks++; if (vq_code[b+1] != 'h0F0 || vq_cyc[b+1] - t0 != 16) begin errors++; $display("FAIL settle_done_ignored: got code %0h at %0d expected code f0 at 16", vq_code[b+1], vq_cyc[b+1] - t0); end
    end
    tick(20);
    checks++; if (vq_tag.size() != b + 2) begin errors++; $display("FAIL settle_extra_result: got %0d results expected %0d", vq_tag.size(), b + 2); end
  endtask

  task automatic test_enable_drop();
    int b;
    bit ok;
    b = vq_tag.size();
    lat_ch = '{10, 10, 10, 0};
    code_ch = '{10'h011, 10'h122, 10'h233, 10'h000};
    bus.enable = 1'b1;
    wait_vcount(b + 1, 100, ok);
    tick(1);
    bus.enable = 1'b0;
    tick(1);
    checks++; if (bus.busy !== 1'b0 || bus.amux_sel !== 2'd0) begin errors++; $display("FAIL drop_settle_idle: got busy %0b amux %0d expected busy 0 amux 0", bus.busy, bus.amux_sel); end
    tick(40);
    checks++; if (vq_tag.size() != b + 1) begin errors++; $display("FAIL drop_settle_no_out: got %0d results expected %0d", vq_tag.size(), b + 1); end
    bus.enable = 1'b1;
    wait_vcount(b + 2, 100, ok);
    checks++; if (!ok || vq_tag[b+1] != 0) begin errors++; $display("FAIL reenable_restart_x: got ok %0b tag %0d expected ok 1 tag 0", ok, ok ? vq_tag[b+1] : -1); end
    tick(6);
    bus.enable = 1'b0;
    wait_vcount(b + 3, 100, ok);
    checks++; if (!ok || vq_tag[b+2] != 1 || vq_code[b+2] != 'h122) begin errors++; $display("FAIL drop_conv_result: got ok %0b tag %0d code %0h expected ok 1 tag 1 code 122", ok, ok ? vq_tag[b+2] : -1, ok ? vq_code[b+2] : -1); end
    checks++; if (bus.busy !== 1'b0 || bus.amux_sel !== 2'd0) begin errors++; $display("FAIL drop_conv_idle: got busy %0b amux %0d expected busy 0 amux 0", bus.busy, bus.amux_sel); end
    tick(40);
    checks++; if (vq_tag.size() != b + 3) begin errors++; $display("FAIL drop_conv_no_out: got %0d results expected %0d", vq_tag.size(), b + 3); end
    bus.enable = 1'b1;
    wait_vcount(b + 4, 100, ok);
    bus.enable = 1'b0;
    checks++; if (!ok || vq_tag[b+3] != 0) begin errors++; $display("FAIL reenable2_restart_x: got ok %0b tag %0d expected ok 1 tag 0", ok, ok ? vq_tag[b+3] : -1); end
    tick(20);
  endtask

  task automatic test_reset_mid();
    int b, t0;
    bit ok;
    bit found;
    b = vq_tag.size();
    lat_ch = '{10, 10, 10, 0};
    code_ch = '{10'h123, 10'h200, 10'h3AB, 10'h000};
    bus.enable = 1'b1;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      tick(1);
      if (bus.adc_start === 1'b1 && bus.amux_sel === 2'd2) found = 1;
    end
    checks++; if (!found) begin errors++; $display("FAIL rstmid_find_z_start: got 0 expected 1"); end
    tick(2);
    rst_n = 1'b0;
    #1;
    checks++; if ({bus.amux_sel, bus.adc_start, bus.adc_code, bus.adc_valid, bus.mux_sel, bus.frame_done, bus.timeout_err, bus.busy} !== 19'h0) begin
      errors++; $display("FAIL rstmid_outputs: got amux %0d start %0b code %0h valid %0b tag %0d frame %0b err %0b busy %0b expected all 0",
        bus.amux_sel, bus.adc_start, bus.adc_code, bus.adc_valid, bus.mux_sel, bus.frame_done, bus.timeout_err, bus.busy); end
    b = vq_tag.size();
    tick(2);
    rst_n = 1'b1;
    t0 = cyc;
    wait_vcount(b + 1, 100, ok);
    bus.enable = 1'b0;
    checks++; if (!ok || vq_tag[b] != 0 || vq_code[b] != 'h123 || vq_cyc[b] - t0 != 16) begin
      errors++; $display("FAIL rstmid_first_result: got ok %0b tag %0d code %0h lat %0d expected ok 1 tag 0 code 123 lat 16",
        ok, ok ? vq_tag[b] : -1, ok ? vq_code[b] : -1, ok ? vq_cyc[b] - t0 : -1); end
    tick(20);
  endtask

  task automatic test_back_to_back();
    int b, fb, tag_err, sp_err;
    bit done;
    b = vq_tag.size();
    fb = frame_cnt;
    lat_q.delete();
    code_ch = '{10'h050, 10'h1A0, 10'h2F0, 10'h000};
    rand_mode = 1;
    bus.enable = 1'b1;
    done = 0;
    for (int i = 0; i < 12000 && !done; i++) begin
      tick(1);
      if (frame_cnt - fb >= 100) done = 1;
    end
    bus.enable = 1'b0;
    rand_mode = 0;
    tick(30);
    checks++; if (!done) begin errors++; $display("FAIL b2b_wait: got %0d frames expected 100", frame_cnt - fb); end
    checks++; if (vq_tag.size() - b != 300) begin errors++; $display("FAIL b2b_result_cnt: got %0d expected 300", vq_tag.size() - b); end
    checks++; if (frame_cnt - fb != 100) begin errors++; $display("FAIL b2b_frame_cnt: got %0d expected 100", frame_cnt - fb); end
    tag_err = 0;
    sp_err = 0;
    for (int j = 0; j < 300 && b + j < vq_tag.size(); j++) begin
      if (vq_tag[b+j] != j % 3) tag_err++;
      if (j > 0 && j < lat_q.size() && vq_cyc[b+j] - vq_cyc[b+j-1] != 5 + lat_q[j]) sp_err++;
    end
    checks++; if (tag_err != 0) begin errors++; $display("FAIL b2b_tag_seq: got %0d bad tags expected 0", tag_err); end
    checks++; if (sp_err != 0) begin errors++; $display("FAIL b2b_spacing: got %0d bad gaps expected 0", sp_err); end
    checks++; if (consec_viol != 0) begin errors++; $display("FAIL valid_consecutive: got %0d expected 0", consec_viol); end
    checks++; if (bad_tag != 0) begin errors++; $display("FAIL tag_value3: got %0d expected 0", bad_tag); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_timeout();
    test_late_done();
    test_enable_drop();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
